// File: rtl/ahb_lite_master.sv
// ahb_lite_master: valid/ready command stream to AHB-Lite SINGLE/NONSEQ initiator, one response per command.
// Define AHBM_PIPELINE_EN to overlap the next address phase with the current data phase.
module ahb_lite_master #(
    parameter int         XLEN  = 32,
    parameter logic [3:0] HPROT = 4'b0011
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic [XLEN-1:0] cmd_addr,
    input  logic            cmd_write,
    input  logic [2:0]      cmd_size,
    input  logic [XLEN-1:0] cmd_wdata,
    output logic            rsp_valid,
    output logic [XLEN-1:0] rsp_rdata,
    output logic            rsp_err,
    output logic [1:0]      htrans,
    output logic            hmastlock,
    output logic [XLEN-1:0] haddr,
    output logic            hwrite,
    output logic [2:0]      hburst,
    output logic [2:0]      hsize,
    output logic [3:0]      hprot,
    output logic [XLEN-1:0] hwdata,
    input  logic [XLEN-1:0] hrdata,
    input  logic            hready,
    input  logic            hresp
);
    logic            a_valid;
    logic            a_write;
    logic [XLEN-1:0] a_addr;
    logic [XLEN-1:0] a_wdata;
    logic [2:0]      a_size;
    logic            d_valid;
    logic            d_write;
    logic [XLEN-1:0] d_wdata;
    logic            err1;
    logic            take;

`ifdef AHBM_PIPELINE_EN
    assign cmd_ready = resetn && !err1 && (!a_valid || hready);
`else
    assign cmd_ready = resetn && !a_valid && !d_valid;
`endif
    assign take      = cmd_valid && cmd_ready;
    // the second error cycle must present IDLE so the held transfer is not sampled
    assign htrans    = (a_valid && !err1) ? 2'b10 : 2'b00;
    assign haddr     = a_addr;
    assign hwrite    = a_write;
    assign hsize     = a_size;
    assign hwdata    = d_wdata;
    assign hmastlock = 1'b0;
    assign hburst    = 3'b000;
    assign hprot     = HPROT;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            a_valid   <= 1'b0;
            a_write   <= 1'b0;
            a_addr    <= '0;
            a_wdata   <= '0;
            a_size    <= 3'd0;
            d_valid   <= 1'b0;
            d_write   <= 1'b0;
            d_wdata   <= '0;
            err1      <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            if (err1) begin
                if (hready) begin
                    rsp_valid <= 1'b1;
                    rsp_err   <= 1'b1;
                    rsp_rdata <= '0;
                    d_valid   <= 1'b0;
                    err1      <= 1'b0;
                end
            end else if (hready) begin
                d_valid <= a_valid;
                d_write <= a_write;
                d_wdata <= a_wdata;
                a_valid <= 1'b0;
                if (d_valid) begin
                    rsp_valid <= 1'b1;
                    rsp_err   <= 1'b0;
                    rsp_rdata <= d_write ? '0 : hrdata;
                end
            end else if (hresp && d_valid) begin
                err1 <= 1'b1;
            end
            if (take) begin
                a_valid <= 1'b1;
                a_addr  <= cmd_addr;
                a_write <= cmd_write;
                a_size  <= cmd_size;
                a_wdata <= cmd_wdata;
            end
        end
    end
endmodule
